// File: rtl/msrh_rob.sv
// msrh reorder buffer: one commit block per dispatch group, in-order retirement, exception flush.
// Optional performance counters are built when MSRH_ROB_PERF_CNT_EN is defined.

package msrh_rob_pkg;
  localparam int RNID_W       = 7;
  localparam int VADDR_W      = 39;
  localparam int CMT_BLK_SIZE = 64;
  localparam int DISP_SIZE    = 5;
  localparam int CMT_BUS_SIZE = 4;
  localparam int CMT_ID_W     = $clog2(CMT_BLK_SIZE);

  typedef struct packed {
    logic                 valid;
    logic [CMT_ID_W-1:0]  cmt_id;
    logic [DISP_SIZE-1:0] grp_id;
    logic                 exc_vld;
  } done_rpt_t;
endpackage

module msrh_rob #(
  parameter int CMT_BLK_SIZE = msrh_rob_pkg::CMT_BLK_SIZE,
  parameter int DISP_SIZE    = msrh_rob_pkg::DISP_SIZE,
  parameter int CMT_BUS_SIZE = msrh_rob_pkg::CMT_BUS_SIZE
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,

  input  logic                                        i_disp_valid,
  output logic                                        o_disp_ready,
  input  logic [msrh_rob_pkg::VADDR_W-2:0]            i_disp_pc_addr,
  input  logic [DISP_SIZE-1:0]                        i_disp_grp_id,
  input  logic [DISP_SIZE-1:0]                        i_disp_old_rd_valid,
  input  logic [DISP_SIZE*msrh_rob_pkg::RNID_W-1:0]   i_disp_old_rd_rnid,
  output logic [$clog2(CMT_BLK_SIZE)-1:0]             o_disp_cmt_id,

  input  msrh_rob_pkg::done_rpt_t                     i_done_rpt [CMT_BUS_SIZE],

  output logic                                        o_cmt_valid,
  output logic [$clog2(CMT_BLK_SIZE)-1:0]             o_cmt_id,
  output logic [msrh_rob_pkg::VADDR_W-2:0]            o_cmt_pc_addr,
  output logic [DISP_SIZE-1:0]                        o_cmt_grp_id,
  output logic [DISP_SIZE-1:0]                        o_cmt_old_rd_valid,
  output logic [DISP_SIZE*msrh_rob_pkg::RNID_W-1:0]   o_cmt_old_rd_rnid,
  output logic                                        o_cmt_exc,
`ifdef MSRH_ROB_PERF_CNT_EN
  output logic [63:0]                                 o_perf_cmt_inst_cnt,
  output logic [31:0]                                 o_perf_full_cycles,
`endif
  output logic                                        o_flush
);

  localparam int CMT_BLK_W = $clog2(CMT_BLK_SIZE);
  localparam int PC_W      = msrh_rob_pkg::VADDR_W - 1;
  localparam int RNIDS_W   = DISP_SIZE * msrh_rob_pkg::RNID_W;

  logic [CMT_BLK_W:0]       head;
  logic [CMT_BLK_W:0]       tail;
  logic [CMT_BLK_W-1:0]     head_idx;
  logic [CMT_BLK_W-1:0]     tail_idx;
  logic                     full;
  logic                     alloc;
  logic                     cmt_fire;
  logic                     exc_flush;
  logic                     flush;

  logic [CMT_BLK_SIZE-1:0]  ent_valid;
  logic [PC_W-1:0]          ent_pc      [CMT_BLK_SIZE];
  logic [DISP_SIZE-1:0]     ent_grp     [CMT_BLK_SIZE];
  logic [DISP_SIZE-1:0]     ent_old_vld [CMT_BLK_SIZE];
  logic [RNIDS_W-1:0]       ent_old_rn  [CMT_BLK_SIZE];
  logic [DISP_SIZE-1:0]     ent_done    [CMT_BLK_SIZE];
  logic                     ent_exc     [CMT_BLK_SIZE];

  logic [DISP_SIZE-1:0]     done_set    [CMT_BLK_SIZE];
  logic                     exc_set     [CMT_BLK_SIZE];

  assign head_idx  = head[CMT_BLK_W-1:0];
  assign tail_idx  = tail[CMT_BLK_W-1:0];
  assign full      = (head_idx == tail_idx) && (head[CMT_BLK_W] != tail[CMT_BLK_W]);
  assign alloc     = i_disp_valid && !full;

  assign o_disp_ready  = !full;
  assign o_disp_cmt_id = tail_idx;

  assign cmt_fire  = ent_valid[head_idx] && (ent_done[head_idx] == ent_grp[head_idx]);
  assign exc_flush = cmt_fire && ent_exc[head_idx];

  assign o_cmt_valid        = cmt_fire;
  assign o_cmt_id           = head_idx;
  assign o_cmt_pc_addr      = ent_pc[head_idx];
  assign o_cmt_grp_id       = ent_grp[head_idx];
  assign o_cmt_old_rd_valid = ent_old_vld[head_idx] & ent_grp[head_idx];
  assign o_cmt_old_rd_rnid  = ent_old_rn[head_idx];
  assign o_cmt_exc          = exc_flush;
  assign o_flush            = flush;

  // Merge all done-report ports into per-entry set masks before applying them.
  always_comb begin
    for (int i = 0; i < CMT_BLK_SIZE; i++) begin
      done_set[i] = '0;
      exc_set[i]  = 1'b0;
    end
    for (int p = 0; p < CMT_BUS_SIZE; p++) begin
      if (i_done_rpt[p].valid) begin
        done_set[i_done_rpt[p].cmt_id] = done_set[i_done_rpt[p].cmt_id] | i_done_rpt[p].grp_id;
        exc_set[i_done_rpt[p].cmt_id]  = exc_set[i_done_rpt[p].cmt_id] | i_done_rpt[p].exc_vld;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      flush     <= 1'b0;
    end else begin
      flush <= exc_flush;
      if (exc_flush) begin
        // Exception retirement empties the ROB; any same-cycle allocation is lost.
        ent_valid <= '0;
        head      <= head + 1'b1;
        tail      <= head + 1'b1;
      end else begin
        if (cmt_fire) begin
          ent_valid[head_idx] <= 1'b0;
          head                <= head + 1'b1;
        end
        if (alloc) begin
          ent_valid[tail_idx] <= 1'b1;
          tail                <= tail + 1'b1;
        end
      end
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < CMT_BLK_SIZE; i++) begin
      if (alloc && (tail_idx == CMT_BLK_W'(i))) begin
        ent_pc[i]      <= i_disp_pc_addr;
        ent_grp[i]     <= i_disp_grp_id;
        ent_old_vld[i] <= i_disp_old_rd_valid;
        ent_old_rn[i]  <= i_disp_old_rd_rnid;
        ent_done[i]    <= '0;
        ent_exc[i]     <= 1'b0;
      end else if (ent_valid[i]) begin
        ent_done[i] <= ent_done[i] | done_set[i];
        ent_exc[i]  <= ent_exc[i] | exc_set[i];
      end
    end
  end

`ifdef MSRH_ROB_PERF_CNT_EN
  function automatic logic [63:0] popcnt(input logic [DISP_SIZE-1:0] v);
    logic [63:0] n;
    n = '0;
    for (int k = 0; k < DISP_SIZE; k++) n = n + 64'(v[k]);
    return n;
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_perf_cmt_inst_cnt <= '0;
      o_perf_full_cycles  <= '0;
    end else begin
      if (cmt_fire) o_perf_cmt_inst_cnt <= o_perf_cmt_inst_cnt + popcnt(ent_grp[head_idx]);
      if (i_disp_valid && full) o_perf_full_cycles <= o_perf_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msrh_rob.sv
// Directed self-checking bench for msrh_rob: basic commit, full/wrap, ordering, merge, exception, reset.

module tb_msrh_rob;
  localparam int DS   = msrh_rob_pkg::DISP_SIZE;
  localparam int NB   = msrh_rob_pkg::CMT_BUS_SIZE;
  localparam int PC_W = msrh_rob_pkg::VADDR_W - 1;
  localparam int RN_W = DS * msrh_rob_pkg::RNID_W;

  logic            clk;
  logic            rst;
  logic            disp_valid;
  logic            disp_ready;
  logic [PC_W-1:0] disp_pc;
  logic [DS-1:0]   disp_grp;
  logic [DS-1:0]   disp_old_vld;
  logic [RN_W-1:0] disp_old_rn;
  logic [5:0]      disp_cmt_id;
  msrh_rob_pkg::done_rpt_t rpt [NB];
  logic            cmt_valid;
  logic [5:0]      cmt_id;
  logic [PC_W-1:0] cmt_pc;
  logic [DS-1:0]   cmt_grp;
  logic [DS-1:0]   cmt_old_vld;
  logic [RN_W-1:0] cmt_old_rn;
  logic            cmt_exc;
  logic            flush;

  int n_checks;
  int n_fail;

  msrh_rob dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_disp_valid        (disp_valid),
    .o_disp_ready        (disp_ready),
    .i_disp_pc_addr      (disp_pc),
    .i_disp_grp_id       (disp_grp),
    .i_disp_old_rd_valid (disp_old_vld),
    .i_disp_old_rd_rnid  (disp_old_rn),
    .o_disp_cmt_id       (disp_cmt_id),
    .i_done_rpt          (rpt),
    .o_cmt_valid         (cmt_valid),
    .o_cmt_id            (cmt_id),
    .o_cmt_pc_addr       (cmt_pc),
    .o_cmt_grp_id        (cmt_grp),
    .o_cmt_old_rd_valid  (cmt_old_vld),
    .o_cmt_old_rd_rnid   (cmt_old_rn),
    .o_cmt_exc           (cmt_exc),
    .o_flush             (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rpt();
    for (int p = 0; p < NB; p++) rpt[p] = '0;
  endtask

  task automatic clear_inputs();
    disp_valid   = 1'b0;
    disp_pc      = '0;
    disp_grp     = '0;
    disp_old_vld = '0;
    disp_old_rn  = '0;
    clear_rpt();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic report(input int p, input int id, input logic [DS-1:0] grp, input logic exc);
    rpt[p].valid   = 1'b1;
    rpt[p].cmt_id  = 6'(id);
    rpt[p].grp_id  = grp;
    rpt[p].exc_vld = exc;
  endtask

  task automatic dispatch(input logic [DS-1:0] grp, input int pc);
    disp_valid   = 1'b1;
    disp_grp     = grp;
    disp_pc      = PC_W'(pc);
    disp_old_vld = 5'b11111;
    disp_old_rn  = RN_W'(pc) + 35'h100;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", disp_ready); end
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmt_valid: got %0b want 0", cmt_valid); end
    n_checks++; if (cmt_exc !== 1'b0) begin n_fail++; $display("FAIL reset_cmt_exc: got %0b want 0", cmt_exc); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0b want 0", flush); end
    n_checks++; if (disp_cmt_id !== 6'd0) begin n_fail++; $display("FAIL reset_disp_id: got %0d want 0", disp_cmt_id); end
  endtask

  task automatic test_basic();
    do_reset();
    disp_valid   = 1'b1;
    disp_grp     = 5'b00011;
    disp_pc      = 38'h123456;
    disp_old_vld = 5'b11011;
    disp_old_rn  = 35'h1_2345_6789;
    n_checks++; if (disp_cmt_id !== 6'd0) begin n_fail++; $display("FAIL basic_disp_id: got %0d want 0", disp_cmt_id); end
    tick();
    disp_valid = 1'b0;
    report(0, 0, 5'b00001, 1'b0);
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_not_done0: got %0b want 0", cmt_valid); end
    tick();
    report(0, 0, 5'b00010, 1'b0);
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_partial: got %0b want 0", cmt_valid); end
    tick();
    clear_rpt();
    n_checks++; if (cmt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_cmt_valid: got %0b want 1", cmt_valid); end
    n_checks++; if (cmt_id !== 6'd0) begin n_fail++; $display("FAIL basic_cmt_id: got %0d want 0", cmt_id); end
    n_checks++; if (cmt_grp !== 5'b00011) begin n_fail++; $display("FAIL basic_cmt_grp: got %b want 00011", cmt_grp); end
    n_checks++; if (cmt_old_vld !== 5'b00011) begin n_fail++; $display("FAIL basic_old_vld: got %b want 00011", cmt_old_vld); end
    n_checks++; if (cmt_pc !== 38'h123456) begin n_fail++; $display("FAIL basic_pc: got %0h want 123456", cmt_pc); end
    n_checks++; if (cmt_old_rn !== 35'h1_2345_6789) begin n_fail++; $display("FAIL basic_rnid: got %0h want 123456789", cmt_old_rn); end
    n_checks++; if (cmt_exc !== 1'b0) begin n_fail++; $display("FAIL basic_exc: got %0b want 0", cmt_exc); end
    tick();
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %0b want 0", cmt_valid); end
    n_checks++; if (disp_cmt_id !== 6'd1) begin n_fail++; $display("FAIL basic_next_id: got %0d want 1", disp_cmt_id); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 64; i++) dispatch(5'b00001, i);
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", disp_ready); end
    n_checks++; if (disp_cmt_id !== 6'd0) begin n_fail++; $display("FAIL full_tail_id: got %0d want 0", disp_cmt_id); end
    dispatch(5'b00001, 'h3ff);
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_drop_ready: got %0b want 0", disp_ready); end
    report(0, 0, 5'b00001, 1'b0);
    tick();
    clear_rpt();
    n_checks++; if (cmt_valid !== 1'b1) begin n_fail++; $display("FAIL full_cmt0_valid: got %0b want 1", cmt_valid); end
    n_checks++; if (cmt_id !== 6'd0) begin n_fail++; $display("FAIL full_cmt0_id: got %0d want 0", cmt_id); end
    n_checks++; if (cmt_pc !== 38'h0) begin n_fail++; $display("FAIL full_cmt0_pc: got %0h want 0", cmt_pc); end
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: got %0b want 0", disp_ready); end
    tick();
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready: got %0b want 1", disp_ready); end
    n_checks++; if (disp_cmt_id !== 6'd0) begin n_fail++; $display("FAIL wrap_id: got %0d want 0", disp_cmt_id); end
    dispatch(5'b00001, 'h55);
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_full_again: got %0b want 0", disp_ready); end
    n_checks++; if (disp_cmt_id !== 6'd1) begin n_fail++; $display("FAIL wrap_tail_id: got %0d want 1", disp_cmt_id); end
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_head_pending: got %0b want 0", cmt_valid); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    dispatch(5'b00001, 10);
    dispatch(5'b00011, 11);
    dispatch(5'b00111, 12);
    report(0, 2, 5'b00111, 1'b0);
    tick();
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wait2: got %0b want 0", cmt_valid); end
    report(0, 1, 5'b00011, 1'b0);
    tick();
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_wait1: got %0b want 0", cmt_valid); end
    report(0, 0, 5'b00001, 1'b0);
    tick();
    clear_rpt();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (cmt_valid !== 1'b1 || cmt_id !== 6'(k)) begin n_fail++; $display("FAIL ooo_commit%0d: got valid %0b id %0d want 1 id %0d", k, cmt_valid, cmt_id, k); end
      tick();
    end
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_drained: got %0b want 0", cmt_valid); end
  endtask

  task automatic test_merge();
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(5'b11111, 20 + i);
    report(0, 0, 5'b11111, 1'b0);
    report(1, 1, 5'b11111, 1'b0);
    report(2, 2, 5'b11111, 1'b0);
    tick();
    clear_rpt();
    report(0, 3, 5'b10000, 1'b0);
    report(1, 3, 5'b01111, 1'b0);
    n_checks++; if (cmt_valid !== 1'b1 || cmt_id !== 6'd0) begin n_fail++; $display("FAIL merge_cmt0: got valid %0b id %0d want 1 id 0", cmt_valid, cmt_id); end
    tick();
    clear_rpt();
    n_checks++; if (cmt_valid !== 1'b1 || cmt_id !== 6'd1) begin n_fail++; $display("FAIL merge_cmt1: got valid %0b id %0d want 1 id 1", cmt_valid, cmt_id); end
    tick();
    n_checks++; if (cmt_valid !== 1'b1 || cmt_id !== 6'd2) begin n_fail++; $display("FAIL merge_cmt2: got valid %0b id %0d want 1 id 2", cmt_valid, cmt_id); end
    tick();
    n_checks++; if (cmt_valid !== 1'b1 || cmt_id !== 6'd3) begin n_fail++; $display("FAIL merge_cmt3: got valid %0b id %0d want 1 id 3", cmt_valid, cmt_id); end
    n_checks++; if (cmt_pc !== 38'd23) begin n_fail++; $display("FAIL merge_pc3: got %0d want 23", cmt_pc); end
    tick();
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL merge_once: got %0b want 0", cmt_valid); end
  endtask

  task automatic test_exception();
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(5'b00001, 30 + i);
    report(0, 1, 5'b00001, 1'b1);
    report(1, 0, 5'b00001, 1'b0);
    report(2, 2, 5'b00001, 1'b0);
    report(3, 3, 5'b00001, 1'b0);
    tick();
    clear_rpt();
    n_checks++; if (cmt_valid !== 1'b1 || cmt_id !== 6'd0 || cmt_exc !== 1'b0) begin n_fail++; $display("FAIL exc_cmt0: got valid %0b id %0d exc %0b want 1 0 0", cmt_valid, cmt_id, cmt_exc); end
    tick();
    n_checks++; if (cmt_valid !== 1'b1 || cmt_id !== 6'd1 || cmt_exc !== 1'b1) begin n_fail++; $display("FAIL exc_cmt1: got valid %0b id %0d exc %0b want 1 1 1", cmt_valid, cmt_id, cmt_exc); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL exc_flush_early: got %0b want 0", flush); end
    disp_valid = 1'b1;
    disp_grp   = 5'b00001;
    tick();
    disp_valid = 1'b0;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL exc_flush: got %0b want 1", flush); end
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL exc_no_cmt2: got %0b want 0", cmt_valid); end
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL exc_ready: got %0b want 1", disp_ready); end
    n_checks++; if (disp_cmt_id !== 6'd2) begin n_fail++; $display("FAIL exc_tail: got %0d want 2", disp_cmt_id); end
    tick();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL exc_flush_pulse: got %0b want 0", flush); end
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL exc_no_cmt3: got %0b want 0", cmt_valid); end
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    for (int i = 0; i < 10; i++) dispatch(5'b00001, 40 + i);
    report(0, 0, 5'b00001, 1'b0);
    tick();
    clear_rpt();
    n_checks++; if (cmt_valid !== 1'b1 || disp_cmt_id !== 6'd10) begin n_fail++; $display("FAIL rst_pre: got valid %0b tail %0d want 1 10", cmt_valid, disp_cmt_id); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", disp_ready); end
    n_checks++; if (cmt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmt_valid: got %0b want 0", cmt_valid); end
    n_checks++; if (disp_cmt_id !== 6'd0) begin n_fail++; $display("FAIL rst_tail: got %0d want 0", disp_cmt_id); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (disp_cmt_id !== 6'd0 || cmt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after: got tail %0d valid %0b want 0 0", disp_cmt_id, cmt_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_full_wrap();
    test_out_of_order();
    test_merge();
    test_exception();
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/msrh_rob.md
# msrh_rob

Reorder buffer for the msrh core. Sits directly downstream of rename/dispatch and consumes the per-pipe `done_rpt_t` completion reports. Allocates one commit block per dispatch group, tracks per-lane completion and exceptions, and retires groups in order. On retirement it returns each lane's old destination rnid to the free lists.

## Interface
Parameters:
- `CMT_BLK_SIZE`, 64: number of commit blocks. Must be a power of two.
- `DISP_SIZE`, 5: lanes per dispatch group.
- `CMT_BUS_SIZE`, 4: number of done-report ports.

Ports (`CMT_BLK_W`=$clog2(CMT_BLK_SIZE); `RNID_W` and `VADDR_W` come from the packages):
- `i_clk` in 1: clock.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_disp_valid` in 1: dispatch group write request.
- `o_disp_ready` out 1: a free block exists.
- `i_disp_pc_addr` in VADDR_W-1: group PC, bits [VADDR_W-1:1].
- `i_disp_grp_id` in DISP_SIZE: valid-lane mask. Must be non-zero.
- `i_disp_old_rd_valid` in DISP_SIZE: lane has an old rd mapping to free.
- `i_disp_old_rd_rnid` in DISP_SIZE*RNID_W: old rnids.
- `o_disp_cmt_id` out CMT_BLK_W: id assigned to the group being dispatched.
- `i_done_rpt` in CMT_BUS_SIZE x `done_rpt_t`: completion reports.
- `o_cmt_valid` out 1: head group retires this cycle.
- `o_cmt_id` out CMT_BLK_W: retiring block id.
- `o_cmt_pc_addr` out VADDR_W-1: retiring group PC.
- `o_cmt_grp_id` out DISP_SIZE: retiring lane mask.
- `o_cmt_old_rd_valid` out DISP_SIZE: free-list return strobes, already ANDed with `grp_id`.
- `o_cmt_old_rd_rnid` out DISP_SIZE*RNID_W: rnids returned to the free lists.
- `o_cmt_exc` out 1: the retiring group carries an exception. Triggers a flush.
- `o_flush` out 1: registered; high for one cycle after an exception commit.

## Operation
Pointers:
- `head` and `tail` are CMT_BLK_W+1 bits wide; the MSB is the wrap bit.
- Empty when `head==tail`.
- Full when the low bits are equal and the MSBs differ.

Allocation:
- `o_disp_ready` = !full. It is derived from registered state only; a same-cycle commit does not bypass it.
- `o_disp_cmt_id` = `tail[CMT_BLK_W-1:0]`.
- On `i_disp_valid && o_disp_ready`, the clock edge writes the entry at tail:
  - `valid`=1
  - `pc_addr`, `grp_id`, `old_rd_*` from the dispatch inputs
  - `done_grp_id`=0, `exc`=0
  - then `tail`++.
- `i_disp_valid` while full: the request is dropped and state is unchanged.

Done reports:
- For each port p with `valid`: if `entry[cmt_id].valid`, then
  - `done_grp_id |= grp_id`
  - `exc |= exc_vld`.
- Multiple ports hitting the same entry in one cycle are OR-merged.
- A report to an invalid entry is ignored.

Commit:
- `o_cmt_valid` = `entry[head].valid && (done_grp_id == grp_id)`. Combinational from registered state.
- The `o_cmt_*` outputs reflect the head entry.
- On `o_cmt_valid`, the edge clears `entry[head].valid` and increments `head`.
- One group retires per cycle at most.

Exception flush:
- If `o_cmt_valid && o_cmt_exc`, the edge clears all entry valids and sets `tail` := `head+1`, so the ROB is empty. `o_flush` is set for one cycle.
- An allocation in the same cycle as an exception commit is discarded.

Simultaneous events:
- Allocation with commit: both occur. Tail and head move independently.
- A done report arriving in the same cycle the entry becomes complete: the entry commits the following cycle.

## Timing
Reset values:
- `head`, `tail`: 0.
- All entry valids: 0.
- `o_disp_ready`: 1.
- `o_cmt_valid`, `o_cmt_exc`, `o_flush`: 0.
- Other outputs: reflect entry 0 with valid low; content is don't-care.

Latency:
- Dispatch at edge N, final done report at edge M≥N+1 → `o_cmt_valid` high in the cycle after edge M.
- Minimum dispatch-to-commit latency is 2 cycles.

Other timing:
- `o_flush` asserts in the cycle after the exception commit.
- Reset may arrive at any point and immediately clears all state.

## Configuration
- `MSRH_ROB_PERF_CNT_EN` defined:
  - Adds output `o_perf_cmt_inst_cnt` (64 bit): accumulates popcount(`o_cmt_grp_id`) on every commit.
  - Adds output `o_perf_full_cycles` (32 bit): counts cycles with `i_disp_valid && !o_disp_ready`.
  - Both counters clear on reset and wrap silently.
- Undefined: the ports and counters do not exist. No other behavioural change.

## Test plan
- **Basic:** dispatch `grp_id`=5'b00011 at cmt_id 0; done report cmt_id 0 grp 5'b00001, next cycle grp 5'b00010 → `o_cmt_valid`=1 for id 0 the cycle after the second report. `o_cmt_old_rd_valid` masked to 5'b00011.
- **Full/wrap:** dispatch 64 groups with no done reports → `o_disp_ready`=0. A 65th request is dropped. Complete id 0 → it commits. The next dispatch gets `o_disp_cmt_id`=0 with the wrap bit toggled.
- **Out-of-order done:** complete ids 2, 1, 0 over 3 cycles → commits retire 0, 1, 2 in consecutive cycles.
- **Merge:** two ports report cmt_id 3 in the same cycle with grp 5'b10000 and 5'b01111 (`grp_id`=5'b11111) → commits once.
- **Exception:** 4 groups in flight; id 1 is done with `exc_vld`=1 and id 0 is done → id 0 commits, then id 1 commits with `o_cmt_exc`=1. Next cycle `o_flush`=1, the ROB is empty and ids 2–3 never commit.
- **Reset mid-flight:** 10 entries valid, assert `i_reset` → `o_disp_ready`=1, `o_cmt_valid`=0, and the next `o_disp_cmt_id`=0.
